// File: rtl/convolution_processor_acc.sv
// Signed multiply-accumulate engine: sums len_i products of data_a_i*data_b_i
// with saturation. It is one dot product per job, started by start_i.
//
// Ports:
//   clk, rst_a           clock, asynchronous active-low reset
//   start_i, len_i       job request and term count (sampled in IDLE/DONE)
//   data_valid_i         operand pair present on data_a_i/data_b_i
//   data_a_i, data_b_i   signed operands
//   data_ready_o         operand pair is accepted this cycle (ACCUM)
//   result_o             saturated sum, held until the next accepted start
//   result_valid_o       one-cycle pulse when result_o is updated
//   busy_o, done_o       in ACCUM / in DONE
//   ovf_o                sticky saturation flag for the current job
module convolution_processor_acc #(
    parameter int DATA_WIDTH = 18,
    parameter int ACC_WIDTH  = 40,
    parameter int LEN_WIDTH  = 6
) (
    input  logic                  clk,
    input  logic                  rst_a,
    input  logic                  start_i,
    input  logic [LEN_WIDTH-1:0]  len_i,
    input  logic                  data_valid_i,
    input  logic [DATA_WIDTH-1:0] data_a_i,
    input  logic [DATA_WIDTH-1:0] data_b_i,
    output logic                  data_ready_o,
    output logic [ACC_WIDTH-1:0]  result_o,
    output logic                  result_valid_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  ovf_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam int PW = 2 * DATA_WIDTH;

    localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    state_t                 state_q, state_d;
    logic [ACC_WIDTH-1:0]   acc_q, acc_d;
    logic [LEN_WIDTH-1:0]   cnt_q, cnt_d;
    logic [ACC_WIDTH-1:0]   res_q, res_d;
    logic                   rv_q, rv_d;
    logic                   ovf_q, ovf_d;

    logic signed [PW-1:0]   prod;
    logic [ACC_WIDTH:0]     acc_ext;
    logic [ACC_WIDTH:0]     prod_ext;
    logic [ACC_WIDTH:0]     sum;
    logic [ACC_WIDTH-1:0]   sum_sat;
    logic                   sat_hit;

    // One guard bit above the accumulator makes the add exact; the guard
    // and the accumulator MSB disagree exactly when the result left range.
    always_comb begin
        prod     = $signed(data_a_i) * $signed(data_b_i);
        acc_ext  = {acc_q[ACC_WIDTH-1], acc_q};
        prod_ext = {{(ACC_WIDTH+1-PW){prod[PW-1]}}, prod};
        sum      = acc_ext + prod_ext;
        sat_hit  = sum[ACC_WIDTH] != sum[ACC_WIDTH-1];
        if (sat_hit) begin
            sum_sat = sum[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
        end else begin
            sum_sat = sum[ACC_WIDTH-1:0];
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        rv_d    = 1'b0;
        ovf_d   = ovf_q;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start_i) begin
                    acc_d = '0;
                    ovf_d = 1'b0;
                    if (len_i != '0) begin
                        cnt_d   = len_i;
                        state_d = S_ACCUM;
                    end else begin
                        cnt_d   = '0;
                        res_d   = '0;
                        rv_d    = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end
            S_ACCUM: begin
                if (data_valid_i) begin
                    acc_d = sum_sat;
                    cnt_d = cnt_q - LEN_WIDTH'(1);
                    if (sat_hit) begin
                        ovf_d = 1'b1;
                    end
                    if (cnt_q == LEN_WIDTH'(1)) begin
                        res_d   = sum_sat;
                        rv_d    = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_a) begin
        if (!rst_a) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
            rv_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            rv_q    <= rv_d;
            ovf_q   <= ovf_d;
        end
    end

    assign data_ready_o   = (state_q == S_ACCUM);
    assign busy_o         = (state_q == S_ACCUM);
    assign done_o         = (state_q == S_DONE);
    assign result_o       = res_q;
    assign result_valid_o = rv_q;
    assign ovf_o          = ovf_q;

endmodule
